regfile_port_sched: RTL and testbench

Port scheduler for the 32-entry general-purpose register file in the multicycle core. The register file has one synchronous read port and one write port. This block serialises each operand fetch (rs, then rt) through the read port and returns both operands with a valid/ready handshake. It also arbitrates the write port round-robin between the writeback stage and the load unit, with write-to-read bypass and hard-wired register 0.

---
 rtl/regfile_port_sched.sv | 131 +++++++++++++
 tb/tb_regfile_port_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sched.sv
// Operand-fetch scheduler for a 1R/1W register file: serialises rs/rt reads,
// applies write bypass and r0 forcing, and round-robins the write port.
module regfile_port_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_rs,
  input  logic [ADDR_W-1:0] fetch_rt,
  output logic              fetch_ready,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              op_ready,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_gnt,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_RS = 3'd1,
    RD_RT = 3'd2,
    CAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              last_ld;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [ADDR_W-1:0] cap_idx;
  logic [DATA_W-1:0] cap_val;
  logic              fetch_fire;

  assign fetch_ready = ~rst & (state == IDLE);
  assign fetch_fire  = fetch_valid & fetch_ready;
  assign op_valid    = (state == DONE);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign rf_raddr    = raddr_q;

  // Read sequencer next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fetch_fire) state_nx = RD_RS; else state_nx = IDLE;
      RD_RS:   state_nx = RD_RT;
      RD_RT:   state_nx = CAP;
      CAP:     state_nx = DONE;
      DONE:    if (op_ready) state_nx = IDLE; else state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Write-port arbiter: single-requester wins outright, conflicts alternate
  always_comb begin
    wb_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst) begin
      wb_gnt = 1'b0;
      ld_gnt = 1'b0;
    end else if (wb_req && ld_req) begin
      if (last_ld) wb_gnt = 1'b1;
      else         ld_gnt = 1'b1;
    end else begin
      wb_gnt = wb_req;
      ld_gnt = ld_req;
    end
    rf_waddr = ld_gnt ? ld_addr : wb_addr;
    rf_wdata = ld_gnt ? ld_data : wb_data;
    rf_we    = (wb_gnt | ld_gnt) & (rf_waddr != {ADDR_W{1'b0}});
  end

  // rf_rdata arriving now belongs to rs (in RD_RT) or rt (in CAP);
  // byp_* remember whether that address was written in the cycle it was driven
  always_comb begin
    cap_idx = (state == CAP) ? rt_q : rs_q;
    if (cap_idx == {ADDR_W{1'b0}}) cap_val = {DATA_W{1'b0}};
    else if (byp_hit)              cap_val = byp_data;
    else                           cap_val = rf_rdata;
  end

  // State, operand capture, read address and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rs_q     <= {ADDR_W{1'b0}};
      rt_q     <= {ADDR_W{1'b0}};
      raddr_q  <= {ADDR_W{1'b0}};
      op_a_q   <= {DATA_W{1'b0}};
      op_b_q   <= {DATA_W{1'b0}};
      byp_hit  <= 1'b0;
      byp_data <= {DATA_W{1'b0}};
      last_ld  <= 1'b1;
    end else begin
      state    <= state_nx;
      byp_hit  <= rf_we & (rf_waddr == raddr_q);
      byp_data <= rf_wdata;
      if (fetch_fire) begin
        rs_q    <= fetch_rs;
        rt_q    <= fetch_rt;
        raddr_q <= fetch_rs;
      end else if (state == RD_RS) begin
        raddr_q <= rt_q;
      end
      if (state == RD_RT) op_a_q <= cap_val;
      if (state == CAP)   op_b_q <= cap_val;
      if (wb_gnt | ld_gnt) last_ld <= ld_gnt;
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a read-first synchronous RF model.
module tb_regfile_port_sched;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid;
  logic [AW-1:0] fetch_rs, fetch_rt;
  logic          fetch_ready;
  logic          op_valid;
  logic [DW-1:0] op_a, op_b;
  logic          op_ready;
  logic          wb_req, ld_req, wb_gnt, ld_gnt;
  logic [AW-1:0] wb_addr, ld_addr;
  logic [DW-1:0] wb_data, ld_data;
  logic [AW-1:0] rf_raddr, rf_waddr;
  logic [DW-1:0] rf_rdata, rf_wdata;
  logic          rf_we;
  logic          pre_en;
  logic [DW-1:0] mem [32];

  int vectors = 0;
  int errors  = 0;

  regfile_port_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_rs(fetch_rs), .fetch_rt(fetch_rt), .fetch_ready(fetch_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    case (i)
      0:       return 32'h0000_DEAD;
      3:       return 32'h0000_0011;
      4:       return 32'h0000_0001;
      5:       return 32'h0000_0055;
      6:       return 32'h0000_0066;
      7:       return 32'h0000_0022;
      8:       return 32'h0000_0033;
      9:       return 32'h0000_0044;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Register-file model: read-first, write lands at the same edge
  always @(posedge clk) begin
    rf_rdata <= mem[rf_raddr];
    if (pre_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end

  task automatic test_reset;
    rst = 1'b1; pre_en = 1'b1;
    wb_req = 1'b1; ld_req = 1'b1; wb_addr = 5'd1; ld_addr = 5'd2;
    @(negedge clk);
    vectors++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL rst_fetch_ready: got %0b expected 0", fetch_ready); end
    vectors++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %0b expected 0", op_valid); end
    vectors++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL rst_ops: got %h/%h expected 0/0", op_a, op_b); end
    vectors++; if (rf_raddr !== 5'd0) begin errors++; $display("FAIL rst_raddr: got %0d expected 0", rf_raddr); end
    vectors++; if ({wb_gnt, ld_gnt, rf_we} !== 3'b000) begin errors++; $display("FAIL rst_grants: got %b expected 000", {wb_gnt, ld_gnt, rf_we}); end
    pre_en = 1'b0; wb_req = 1'b0; ld_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    vectors++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b expected 1", fetch_ready); end
  endtask

  task automatic test_basic;
    fetch_valid = 1'b1; fetch_rs = 5'd3; fetch_rt = 5'd7; op_ready = 1'b1;
    #1;
    vectors++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %0b expected 1", fetch_ready); end
    @(negedge clk); fetch_valid = 1'b0;
    vectors++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %0b expected 0", fetch_ready); end
    vectors++; if (rf_raddr !== 5'd3) begin errors++; $display("FAIL basic_raddr_rs: got %0d expected 3", rf_raddr); end
    @(negedge clk);
    vectors++; if (rf_raddr !== 5'd7) begin errors++; $display("FAIL basic_raddr_rt: got %0d expected 7", rf_raddr); end
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", op_valid); end
    @(negedge clk);
    vectors++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", op_valid); end
    vectors++; if (op_a !== 32'h11) begin errors++; $display("FAIL basic_op_a: got %h expected 11", op_a); end
    vectors++; if (op_b !== 32'h22) begin errors++; $display("FAIL basic_op_b: got %h expected 22", op_b); end
    @(negedge clk);
    vectors++; if (fetch_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL basic_return: got ready=%0b valid=%0b expected 1/0", fetch_ready, op_valid); end
    vectors++; if (rf_raddr !== 5'd7) begin errors++; $display("FAIL basic_raddr_hold: got %0d expected 7", rf_raddr); end
  endtask

  task automatic test_zero;
    fetch_valid = 1'b1; fetch_rs = 5'd0; fetch_rt = 5'd0; op_ready = 1'b1;
    @(negedge clk); fetch_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (op_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL zero_ops: got v=%0b %h/%h expected 1 0/0", op_valid, op_a, op_b); end
    ld_req = 1'b1; ld_addr = 5'd0; ld_data = 32'h5;
    #1;
    vectors++; if (ld_gnt !== 1'b1 || wb_gnt !== 1'b0) begin errors++; $display("FAIL zero_ld_gnt: got ld=%0b wb=%0b expected 1/0", ld_gnt, wb_gnt); end
    vectors++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %0b expected 0", rf_we); end
    @(negedge clk); ld_req = 1'b0;
  endtask

  task automatic test_bypass;
    fetch_valid = 1'b1; fetch_rs = 5'd4; fetch_rt = 5'd4; op_ready = 1'b1;
    @(negedge clk); fetch_valid = 1'b0;
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'hAB;
    #1;
    vectors++; if (wb_gnt !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL byp_wb_write: got gnt=%0b we=%0b expected 1/1", wb_gnt, rf_we); end
    @(negedge clk); wb_req = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (op_a !== 32'hAB) begin errors++; $display("FAIL byp_rs_op_a: got %h expected ab", op_a); end
    vectors++; if (op_b !== 32'hAB) begin errors++; $display("FAIL byp_rs_op_b: got %h expected ab", op_b); end
    @(negedge clk);
    fetch_valid = 1'b1; fetch_rs = 5'd5; fetch_rt = 5'd6;
    @(negedge clk); fetch_valid = 1'b0;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 5'd6; ld_data = 32'h77;
    #1;
    vectors++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL byp_ld_gnt: got %0b expected 1", ld_gnt); end
    @(negedge clk); ld_req = 1'b0;
    @(negedge clk);
    vectors++; if (op_a !== 32'h55) begin errors++; $display("FAIL byp_rt_op_a: got %h expected 55", op_a); end
    vectors++; if (op_b !== 32'h77) begin errors++; $display("FAIL byp_rt_op_b: got %h expected 77", op_b); end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic exp_wb;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wb_req = 1'b1; ld_req = 1'b1; wb_addr = 5'd10; ld_addr = 5'd11;
    wb_data = 32'hA; ld_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      exp_wb = (i % 2 == 0);
      #1;
      vectors++; if (wb_gnt !== exp_wb || ld_gnt !== ~exp_wb) begin errors++; $display("FAIL rr_alt%0d: got wb=%0b ld=%0b expected wb=%0b", i, wb_gnt, ld_gnt, exp_wb); end
      vectors++; if (rf_waddr !== (exp_wb ? 5'd10 : 5'd11)) begin errors++; $display("FAIL rr_waddr%0d: got %0d expected %0d", i, rf_waddr, exp_wb ? 10 : 11); end
      @(negedge clk);
    end
    ld_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (wb_gnt !== 1'b1 || ld_gnt !== 1'b0) begin errors++; $display("FAIL rr_wb_only%0d: got wb=%0b ld=%0b expected 1/0", i, wb_gnt, ld_gnt); end
      @(negedge clk);
    end
    wb_req = 1'b0; ld_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (ld_gnt !== 1'b1 || wb_gnt !== 1'b0) begin errors++; $display("FAIL rr_ld_only%0d: got ld=%0b wb=%0b expected 1/0", i, ld_gnt, wb_gnt); end
      @(negedge clk);
    end
    ld_req = 1'b0;
  endtask

  task automatic test_backpressure;
    fetch_valid = 1'b1; fetch_rs = 5'd8; fetch_rt = 5'd9; op_ready = 1'b0;
    @(negedge clk); fetch_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (op_valid !== 1'b1 || fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_flags%0d: got v=%0b r=%0b expected 1/0", i, op_valid, fetch_ready); end
      vectors++; if (op_a !== 32'h33 || op_b !== 32'h44) begin errors++; $display("FAIL bp_ops%0d: got %h/%h expected 33/44", i, op_a, op_b); end
      wb_req = 1'b1; wb_addr = 5'd8; wb_data = 32'h1000 + i;
      fetch_valid = 1'b1; fetch_rs = 5'd1;
      @(negedge clk);
    end
    wb_req = 1'b0; fetch_valid = 1'b0; op_ready = 1'b1;
    vectors++; if (op_a !== 32'h33 || op_b !== 32'h44 || op_valid !== 1'b1) begin errors++; $display("FAIL bp_after_writes: got v=%0b %h/%h expected 1 33/44", op_valid, op_a, op_b); end
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%0b r=%0b expected 0/1", op_valid, fetch_ready); end
  endtask

  task automatic test_reset_mid;
    fetch_valid = 1'b1; fetch_rs = 5'd3; fetch_rt = 5'd7; op_ready = 1'b1;
    @(negedge clk); fetch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; wb_req = 1'b1; ld_req = 1'b1; wb_addr = 5'd12; ld_addr = 5'd13;
    #1;
    vectors++; if ({wb_gnt, ld_gnt, rf_we, fetch_ready} !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnts: got %b expected 0000", {wb_gnt, ld_gnt, rf_we, fetch_ready}); end
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL mid_rst_ops: got v=%0b %h/%h expected 0 0/0", op_valid, op_a, op_b); end
    vectors++; if (rf_raddr !== 5'd0 || wb_gnt !== 1'b0 || ld_gnt !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got raddr=%0d wb=%0b ld=%0b expected 0/0/0", rf_raddr, wb_gnt, ld_gnt); end
    rst = 1'b0; wb_req = 1'b0; ld_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (op_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL mid_no_result%0d: got v=%0b r=%0b expected 0/1", i, op_valid, fetch_ready); end
    end
  endtask

  initial begin
    fetch_valid = 1'b0; fetch_rs = 5'd0; fetch_rt = 5'd0; op_ready = 1'b0;
    wb_req = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ld_req = 1'b0; ld_addr = 5'd0; ld_data = 32'h0;
    pre_en = 1'b0; rst = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
